// File: rtl/mcp_pkg.sv
// Shared definitions for the multi-cycle-path (MCP) crossing.
// The send and receive FSMs use the same two-state encoding.
package mcp_pkg;

    typedef enum logic {
        MCP_READY = 1'b0,
        MCP_BUSY  = 1'b1
    } mcp_state_t;

endpackage

// File: rtl/pulse_gen.sv
// Toggle-to-pulse converter.
// Emits a one-cycle pulse on every change of d_i.
// Ports:
//   clk     - clock
//   rst_n   - asynchronous, active-low reset
//   d_i     - level/toggle input, already synchronous to clk
//   pulse_o - high for one cycle after each change of d_i
module pulse_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic pulse_o
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    // Combinational, so the pulse appears in the cycle right after d_i changes.
    assign pulse_o = d_i ^ d_q;

endmodule

// File: rtl/a_mcp_send.sv
// Sending side of the MCP clock-domain crossing (aclk domain).
// The block captures a source word and holds it on adata. It then flips
// a_en to announce the word. It waits for the b domain to answer with a
// b_ack toggle. A one-word pending buffer absorbs the next word while the
// current one is in flight.
// Ports:
//   aclk, arst - clock and asynchronous active-high reset
//   adatain    - word from the source
//   asend      - source offers adatain
//   aready     - block can accept a word this cycle
//   adata      - held word (crosses unsynchronized)
//   a_en       - toggle, each flip announces a new adata
//   b_ack      - acknowledge toggle from the b domain (unsynchronized)
//   abusy      - a word is in flight
//   acount     - number of acknowledged words, wraps
module a_mcp_send
    import mcp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic [WIDTH-1:0] adatain,
    input  logic             asend,
    output logic             aready,
    output logic [WIDTH-1:0] adata,
    output logic             a_en,
    input  logic             b_ack,
    output logic             abusy,
    output logic [CNT_W-1:0] acount
);

    logic             aq1_ack_q;
    logic             aq2_ack_q;
    logic             a_ack;
    logic             accept;

    mcp_state_t       state_q;
    logic [WIDTH-1:0] adata_q;
    logic             a_en_q;
    logic             aready_q;
    logic             abusy_q;
    logic [WIDTH-1:0] pend_q;
    logic             pend_v_q;
    logic [CNT_W-1:0] acount_q;
    logic [CNT_W-1:0] acount_d;

    // Two-flop synchronizer for the incoming acknowledge toggle.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            aq1_ack_q <= 1'b0;
            aq2_ack_q <= 1'b0;
        end else begin
            aq1_ack_q <= b_ack;
            aq2_ack_q <= aq1_ack_q;
        end
    end

    pulse_gen u_ack_pulse (
        .clk     (aclk),
        .rst_n   (~arst),
        .d_i     (aq2_ack_q),
        .pulse_o (a_ack)
    );

    // aready_q always mirrors ~pend_v_q, so there can be no accept
    // while a word is pending.
    assign accept   = asend & aready_q;
    assign acount_d = acount_q + CNT_W'(1);

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q  <= MCP_READY;
            adata_q  <= '0;
            a_en_q   <= 1'b0;
            aready_q <= 1'b1;
            abusy_q  <= 1'b0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            acount_q <= '0;
        end else begin
            case (state_q)
                MCP_READY: begin
                    // An ack seen here is a protocol violation and is ignored.
                    if (accept) begin
                        adata_q <= adatain;
                        a_en_q  <= ~a_en_q;
                        abusy_q <= 1'b1;
                        state_q <= MCP_BUSY;
                    end
                end
                MCP_BUSY: begin
                    if (a_ack) begin
                        acount_q <= acount_d;
                        if (pend_v_q) begin
                            adata_q  <= pend_q;
                            a_en_q   <= ~a_en_q;
                            pend_v_q <= 1'b0;
                            aready_q <= 1'b1;
                        end else if (accept) begin
                            adata_q <= adatain;
                            a_en_q  <= ~a_en_q;
                        end else begin
                            abusy_q <= 1'b0;
                            state_q <= MCP_READY;
                        end
                    end else if (accept) begin
                        // adata stays frozen until its ack, so park the word.
                        pend_q   <= adatain;
                        pend_v_q <= 1'b1;
                        aready_q <= 1'b0;
                    end
                end
                default: state_q <= MCP_READY;
            endcase
        end
    end

    assign aready = aready_q;
    assign adata  = adata_q;
    assign a_en   = a_en_q;
    assign abusy  = abusy_q;
    assign acount = acount_q;

endmodule

// File: tb/tb_a_mcp_send.sv
module tb_a_mcp_send;

    logic        aclk = 1'b0;
    logic        arst;
    logic [7:0]  adatain;
    logic        asend;
    logic        b_ack;

    logic        aready, a_en, abusy;
    logic [7:0]  adata;
    logic [15:0] acount;

    logic        aready4, a_en4, abusy4;
    logic [7:0]  adata4;
    logic [3:0]  acount4;

    int errs   = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    a_mcp_send #(.WIDTH(8), .CNT_W(16)) dut (
        .aclk(aclk), .arst(arst), .adatain(adatain), .asend(asend),
        .aready(aready), .adata(adata), .a_en(a_en), .b_ack(b_ack),
        .abusy(abusy), .acount(acount)
    );

    a_mcp_send #(.WIDTH(8), .CNT_W(4)) dut4 (
        .aclk(aclk), .arst(arst), .adatain(adatain), .asend(asend),
        .aready(aready4), .adata(adata4), .a_en(a_en4), .b_ack(b_ack),
        .abusy(abusy4), .acount(acount4)
    );

    // Reference model. Words in flight are kept in a queue. The front entry
    // is the one presented on adata, and a second entry is the waiting word.
    // An ack retires the front entry. Whenever a new entry becomes the front,
    // it is presented and the announce toggle flips.
    logic [7:0] q[$];
    logic [7:0] m_adata;
    logic       m_aen;
    int         m_cnt;
    logic       smp[3];   // b_ack samples at the last three edges, [0] newest
    logic       prev_adata_valid;
    logic [7:0] prev_adata;
    logic       prev_aen;

    task automatic model_reset();
        q.delete();
        m_adata = 8'h00;
        m_aen   = 1'b0;
        m_cnt   = 0;
        for (int i = 0; i < 3; i++) smp[i] = 1'b0;
        prev_adata_valid = 1'b0;
    endtask

    // Called just after a rising edge with the inputs that edge saw.
    task automatic model_step();
        bit ack, acc;
        // A b_ack change takes effect two edges after it is first sampled.
        ack = (smp[1] != smp[2]);
        acc = asend && (q.size() < 2);
        if (ack && q.size() > 0) begin
            void'(q.pop_front());
            m_cnt++;
            if (q.size() > 0) begin
                m_adata = q[0];
                m_aen   = ~m_aen;
            end
        end
        if (acc) begin
            q.push_back(adatain);
            if (q.size() == 1) begin
                m_adata = adatain;
                m_aen   = ~m_aen;
            end
        end
        smp[2] = smp[1];
        smp[1] = smp[0];
        smp[0] = b_ack;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("adata",   {24'h0, adata},  {24'h0, m_adata});
        chk("a_en",    {31'h0, a_en},   {31'h0, m_aen});
        chk("aready",  {31'h0, aready}, {31'h0, (q.size() < 2)});
        chk("abusy",   {31'h0, abusy},  {31'h0, (q.size() > 0)});
        chk("acount",  {16'h0, acount}, m_cnt & 32'hFFFF);
        chk("acount4", {28'h0, acount4}, m_cnt & 32'hF);
        chk("adata4",  {24'h0, adata4}, {24'h0, m_adata});
        chk("a_en4",   {31'h0, a_en4},  {31'h0, m_aen});
        if (prev_adata_valid)
            chk("adata_stable", {31'h0, (adata != prev_adata) && (a_en == prev_aen)}, 32'h0);
        prev_adata_valid = 1'b1;
        prev_adata = adata;
        prev_aen   = a_en;
    endtask

    // Drive at the falling edge, clock once, then compare at the next falling edge.
    task automatic cycle(input logic snd, input logic [7:0] din, input logic back);
        asend   = snd;
        adatain = din;
        b_ack   = back;
        @(posedge aclk);
        model_step();
        @(negedge aclk);
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_adata"},  {24'h0, adata},  32'h0);
        chk({tag, "_a_en"},   {31'h0, a_en},   32'h0);
        chk({tag, "_aready"}, {31'h0, aready}, 32'h1);
        chk({tag, "_abusy"},  {31'h0, abusy},  32'h0);
        chk({tag, "_acount"}, {16'h0, acount}, 32'h0);
    endtask

    typedef struct {
        logic       snd;
        logic [7:0] din;
        logic       back;
        logic [7:0] e_adata;
        logic       e_aen;
        logic       e_rdy;
        logic       e_busy;
        int         e_cnt;
    } vec_t;

    vec_t tbl[27];
    logic back;

    task automatic do_transfer(input logic [7:0] din);
        cycle(1'b1, din, back);
        back = ~back;
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, back);
    endtask

    initial begin
        // single word, back-to-back, ack+accept with pend empty, stray ack
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 0};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 0};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1};
        tbl[4]  = '{1'b1, 8'h11, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1};
        tbl[5]  = '{1'b1, 8'h22, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1};
        tbl[6]  = '{1'b1, 8'h33, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h22, 1'b1, 1'b1, 1'b1, 2};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 2};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 2};
        tbl[12] = '{1'b1, 8'h33, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 3};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 3};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 3};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 4};
        tbl[16] = '{1'b1, 8'h40, 1'b0, 8'h40, 1'b1, 1'b1, 1'b1, 4};
        tbl[17] = '{1'b0, 8'h00, 1'b1, 8'h40, 1'b1, 1'b1, 1'b1, 4};
        tbl[18] = '{1'b0, 8'h00, 1'b1, 8'h40, 1'b1, 1'b1, 1'b1, 4};
        tbl[19] = '{1'b1, 8'h5C, 1'b1, 8'h5C, 1'b0, 1'b1, 1'b1, 5};
        tbl[20] = '{1'b0, 8'h00, 1'b0, 8'h5C, 1'b0, 1'b1, 1'b1, 5};
        tbl[21] = '{1'b0, 8'h00, 1'b0, 8'h5C, 1'b0, 1'b1, 1'b1, 5};
        tbl[22] = '{1'b0, 8'h00, 1'b0, 8'h5C, 1'b0, 1'b1, 1'b0, 6};
        tbl[23] = '{1'b0, 8'h00, 1'b1, 8'h5C, 1'b0, 1'b1, 1'b0, 6};
        tbl[24] = '{1'b0, 8'h00, 1'b1, 8'h5C, 1'b0, 1'b1, 1'b0, 6};
        tbl[25] = '{1'b0, 8'h00, 1'b1, 8'h5C, 1'b0, 1'b1, 1'b0, 6};
        tbl[26] = '{1'b0, 8'h00, 1'b1, 8'h5C, 1'b0, 1'b1, 1'b0, 6};

        arst = 1'b1; asend = 1'b0; adatain = 8'h00; b_ack = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("por");
        @(negedge aclk);
        @(negedge aclk);
        arst = 1'b0;

        for (int i = 0; i < 27; i++) begin
            cycle(tbl[i].snd, tbl[i].din, tbl[i].back);
            $display("vec %0d: snd=%0d din=%02h back=%0d -> adata=%02h a_en=%0d aready=%0d abusy=%0d acount=%0d",
                     i, tbl[i].snd, tbl[i].din, tbl[i].back, adata, a_en, aready, abusy, acount);
            chk("tbl_adata",  {24'h0, adata},  {24'h0, tbl[i].e_adata});
            chk("tbl_a_en",   {31'h0, a_en},   {31'h0, tbl[i].e_aen});
            chk("tbl_aready", {31'h0, aready}, {31'h0, tbl[i].e_rdy});
            chk("tbl_abusy",  {31'h0, abusy},  {31'h0, tbl[i].e_busy});
            chk("tbl_acount", {16'h0, acount}, tbl[i].e_cnt);
        end

        // Reset while BUSY with a pending word.
        back = b_ack;
        cycle(1'b1, 8'hAA, back);
        cycle(1'b1, 8'hBB, back);
        chk("pre_rst_aready", {31'h0, aready}, 32'h0);
        arst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        b_ack = 1'b0; asend = 1'b0;
        model_reset();
        @(negedge aclk);
        @(negedge aclk);
        arst = 1'b0;
        back = 1'b0;
        cycle(1'b1, 8'hC3, back);
        $display("post-reset transfer: adata=%02h a_en=%0d abusy=%0d", adata, a_en, abusy);
        chk("post_rst_adata", {24'h0, adata}, 32'hC3);
        chk("post_rst_a_en",  {31'h0, a_en},  32'h1);
        back = ~back;
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, back);

        // Counter wrap: 17 transfers from reset on the 4-bit counter.
        arst = 1'b1;
        b_ack = 1'b0;
        model_reset();
        @(negedge aclk);
        arst = 1'b0;
        back = 1'b0;
        for (int t = 0; t < 17; t++) begin
            do_transfer(8'(t * 7 + 3));
            $display("wrap xfer %0d: acount=%0d acount4=%0d", t, acount, acount4);
        end
        chk("wrap_acount4", {28'h0, acount4}, 32'h1);
        chk("wrap_acount",  {16'h0, acount},  32'd17);

        // Randomized traffic with arbitrary ack toggles.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) back = ~back;
            cycle(1'($urandom_range(0, 1)), 8'($urandom), back);
        end
        $display("random phase done: acount=%0d", acount);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
